ecc_secded_pipe: RTL
====================

// Module: ecc_secded_pipe
// PURPOSE
//  Parametrised extended-Hamming SECDED encoder plus pipelined decoder for FIFO/RAM protection.
//  Encoder is combinational on the write side. Decoder is a registered stream stage with
//  valid/ready handshake, correction, bypass, saturating error counters and a first-error log.
//  Sits between RAM read data and the FIFO read port.
// PARAMETERS
//  DATA_WIDTH    64  data bits per word, 1..120
//  PARITY_WIDTH   8  check bits incl. overall parity; must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH
//  CNT_WIDTH     16  width of each saturating error counter
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  enc_data     in   DW   write-side data
//  enc_parity   out  PW   check bits for enc_data (combinational)
//  in_valid     in   1    read word valid
//  in_ready     out  1    decoder accepts word
//  in_data      in   DW   read data
//  in_parity    in   PW   read check bits
//  bypass       in   1    sampled with the word; forces raw pass-through, no flags, no counting
//  out_valid    out  1    decoded word valid
//  out_ready    in   1    downstream accepts
//  out_data     out  DW   corrected data
//  out_syndrome out  PW   {overall, position} syndrome of the word
//  sbit_err     out  1    single-bit error corrected (qualified by out_valid)
//  dbit_err     out  1    uncorrectable error (qualified by out_valid)
//  sbit_cnt     out  CW   saturating count of sbit_err words
//  dbit_cnt     out  CW   saturating count of dbit_err words
//  cnt_clr      in   1    clears counters and error log
//  log_valid    out  1    first error captured
//  log_syndrome out  PW   syndrome of first error since reset/clear
// BEHAVIOUR
//  Encoding: Hamming positions 1..2^(PW-1)-1. Check bit i sits at position 2^i for i<PW-1.
//   Data bit k takes the k-th non-power-of-two position, ascending (d0=3, d1=5, d2=6, d3=7, d4=9 ...).
//   p[i] = XOR of data whose position has bit i set.
//   p[PW-1] = XOR of all data and p[PW-2:0].
//  Decode: s = recomputed p[PW-2:0] ^ in_parity[PW-2:0]; ov = XOR of all received bits.
//   ov=0,s=0  -> clean.
//   ov=1,s=0  -> overall bit error; sbit, data unchanged.
//   ov=1,s=power of two -> check bit error; sbit, data unchanged.
//   ov=1,s=data position -> flip that data bit; sbit.
//   ov=1,s beyond last data position -> dbit, data raw.
//   ov=0,s!=0 -> dbit, data raw.
//   out_syndrome = {ov, s}.
//  Handshake: in_ready = !out_valid | out_ready.
//   Transfer on in_valid&in_ready; result registered, latency 1 cycle.
//   out_* held stable while out_valid & !out_ready. Full throughput of 1 word/cycle.
//  Bypass: out_data = in_data, sbit/dbit = 0, syndrome still reported, no count, no log.
//  Counters: +1 on each out_valid&out_ready beat with the flag set; saturate at all-ones.
//   cnt_clr wins over a simultaneous increment (result 0).
//  Log: on the first accepted error beat with log_valid=0, capture syndrome and set log_valid.
//   Held until cnt_clr. cnt_clr in the same cycle as an error beat -> log cleared, not captured.
//  Reset: out_valid=0, out_data=0, out_syndrome=0, sbit/dbit=0, counters=0, log_valid=0,
//   log_syndrome=0. in_ready=1 after reset. Reset mid-stream drops the in-flight word.
// CONFIGURATION
//  ECC_PIPE2_EN defined: adds a syndrome register stage between syndrome compute and correction.
//   Latency 2, still 1 word/cycle. in_ready obeys the same rule, applied per stage.
//   Stall back-pressures both stages.
//  ECC_PIPE2_EN undefined: single stage, latency 1.
//  Flags, counts and log are identical in both builds.
// TESTING (DW=64, PW=8)
//  1. Clean word 0xDEADBEEF_01234567 with its own parity -> same data out, syndrome 0x00, no flags, latency 1 (2 with ECC_PIPE2_EN).
//  2. Flip data bit 0 -> syndrome 0x83, data corrected, sbit_err=1, sbit_cnt=1, log_syndrome=0x83.
//  3. Flip data bits 0 and 1 -> syndrome 0x06, dbit_err=1, data raw; flip p[2] only -> 0x84, sbit, data unchanged.
//  4. Hold out_ready=0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, no word lost or duplicated, counters +1 only on the accepted beat.
//  5. Preload sbit_cnt to 0xFFFE, send 3 single-bit errors -> saturates at 0xFFFF; cnt_clr together with an error beat -> 0, log_valid=0.
//  6. Bypass=1 with a double-bit error -> raw data, no flags, counters unchanged; rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: extended-Hamming SECDED encoder (combinational, write side)
// plus a registered decoder stream stage with correction, bypass, saturating
// error counters and a first-error syndrome log.
// Optional build macro ECC_PIPE2_EN: inserts a syndrome register stage ahead of
// correction (latency 2, still one word per cycle). Undefined: latency 1.
module ecc_secded_pipe #(
    parameter int DATA_WIDTH   = 64,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   enc_data,
    output logic [PARITY_WIDTH-1:0] enc_parity,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [PARITY_WIDTH-1:0] in_parity,
    input  logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_syndrome,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    input  logic                    cnt_clr,
    output logic                    log_valid,
    output logic [PARITY_WIDTH-1:0] log_syndrome
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PARITY_WIDTH;
    localparam int HW = PW - 1;   // Hamming (position) check bits

    typedef logic [DW-1:0][HW-1:0] pos_tab_t;
    typedef logic [HW-1:0][DW-1:0] mask_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [PW-1:0] syn;
        logic          sbit;
        logic          dbit;
    } dec_t;

    // Codeword position of each data bit: non-powers-of-two, ascending from 3.
    function automatic pos_tab_t build_pos();
        pos_tab_t tab;
        int       p;
        tab = '0;
        p   = 3;
        for (int k = 0; k < DW; k++) begin
            if ((p & (p - 1)) == 0) p++;
            tab[k] = HW'(p);
            p++;
        end
        return tab;
    endfunction

    // Per check bit, which data bits feed it (position has that bit set).
    function automatic mask_t build_masks();
        mask_t    m;
        pos_tab_t pos;
        pos = build_pos();
        m   = '0;
        for (int i = 0; i < HW; i++)
            for (int k = 0; k < DW; k++)
                m[i][k] = pos[k][i];
        return m;
    endfunction

    localparam pos_tab_t      POS      = build_pos();
    localparam mask_t         MASK     = build_masks();
    localparam logic [HW-1:0] LAST_POS = POS[DW-1];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Classify a syndrome and apply the single-bit fix when it lands on data.
    function automatic dec_t correct(input logic [DW-1:0] d,
                                     input logic [PW-1:0] syn,
                                     input logic          byp);
        dec_t          r;
        logic [HW-1:0] s;
        logic          ov;
        s      = syn[HW-1:0];
        ov     = syn[PW-1];
        r.data = d;
        r.syn  = syn;
        r.sbit = 1'b0;
        r.dbit = 1'b0;
        if (!byp) begin
            if (!ov) begin
                r.dbit = (s != '0);
            end else if ((s & (s - HW'(1))) == '0) begin
                // overall bit or a check bit flipped: data already good
                r.sbit = 1'b1;
            end else if (s > LAST_POS) begin
                r.dbit = 1'b1;
            end else begin
                r.sbit = 1'b1;
                for (int k = 0; k < DW; k++)
                    if (POS[k] == s) r.data[k] = ~d[k];
            end
        end
        return r;
    endfunction

    logic [HW-1:0] enc_hp;
    logic [HW-1:0] rd_hp;
    logic [PW-1:0] rd_syn;

    for (genvar i = 0; i < HW; i++) begin : g_chk
        assign enc_hp[i] = ^(enc_data & MASK[i]);
        assign rd_hp[i]  = ^(in_data & MASK[i]);
    end

    assign enc_parity = {(^enc_data) ^ (^enc_hp), enc_hp};
    assign rd_syn     = {^{in_data, in_parity}, rd_hp ^ in_parity[HW-1:0]};

    logic out_adv;
    logic st_valid;
    dec_t dec;

    assign out_adv = !out_valid | out_ready;

`ifdef ECC_PIPE2_EN
    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic [PW-1:0] s1_syn;
    logic          s1_byp;

    assign in_ready = !s1_valid | out_adv;
    assign st_valid = s1_valid;
    assign dec      = correct(s1_data, s1_syn, s1_byp);

    // Syndrome stage: holds while the output stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_byp   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_syn  <= rd_syn;
                s1_byp  <= bypass;
            end
        end
    end
`else
    assign in_ready = out_adv;
    assign st_valid = in_valid;
    assign dec      = correct(in_data, rd_syn, bypass);
`endif

    // Output stage: load a new result whenever the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            sbit_err     <= 1'b0;
            dbit_err     <= 1'b0;
        end else if (out_adv) begin
            out_valid <= st_valid;
            if (st_valid) begin
                out_data     <= dec.data;
                out_syndrome <= dec.syn;
                sbit_err     <= dec.sbit;
                dbit_err     <= dec.dbit;
            end
        end
    end

    logic beat;
    assign beat = out_valid & out_ready;

    // Saturating error counters, counted on accepted beats; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else if (beat) begin
            if (sbit_err && sbit_cnt != CNT_MAX) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
            if (dbit_err && dbit_cnt != CNT_MAX) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
        end
    end

    // First-error log: latch the syndrome of the first accepted error beat.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            log_valid    <= 1'b0;
            log_syndrome <= '0;
        end else if (beat && !log_valid && (sbit_err || dbit_err)) begin
            log_valid    <= 1'b1;
            log_syndrome <= out_syndrome;
        end
    end

endmodule
